// File: rtl/exec_ctrl_pkg.sv
// rtl/exec_ctrl_pkg.sv - shared types, widths and parameter check for the run-control block
// Purpose: debounce FSM state encoding, min-high hold counter width, MIN_HIGH legality check.
// Ports: none (package).
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int HOLD_W = 4;

  // The execution stage needs 5 high cycles to leave reset, and MIN_HIGH-1 must fit the hold counter.
  function automatic bit min_high_ok(input int min_high);
    return (min_high >= 5) && (min_high <= (1 << HOLD_W));
  endfunction

endpackage

// File: rtl/exec_button_ctrl_if.sv
// rtl/exec_button_ctrl_if.sv - button/halt in, run level out, bundled as one port
// Purpose: groups the run-control signals between the board/core side and exec_button_ctrl.
// Signals: btn_raw (raw button), halt (core halt level), exec (run level),
//          btn_pulse (accepted press strobe), running (status copy of exec).
// Modports: master = driver of btn_raw/halt, slave = exec_button_ctrl.
interface exec_button_ctrl_if;
  logic btn_raw;
  logic halt;
  logic exec;
  logic btn_pulse;
  logic running;

  modport master (output btn_raw, output halt, input exec, input btn_pulse, input running);
  modport slave  (input btn_raw, input halt, output exec, output btn_pulse, output running);
endinterface

// File: rtl/btn_sync_debounce.sv
// rtl/btn_sync_debounce.sv - two-flop synchroniser plus debounce FSM producing one strobe per press
// Purpose: accept a press/release only after DEBOUNCE_CYCLES stable synchronised cycles.
// Ports: i_clk, i_rst (async active-high), i_btn_raw (async bouncy button),
//        o_btn_pulse (one-cycle strobe per accepted press).
module btn_sync_debounce
  import exec_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_btn_pulse
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_btn_s;
  logic [1:0]       r_warm;
  logic             r_armed;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;

  // r_warm marks when r_btn_s reflects the real button again after reset; until the button is
  // then seen released (r_armed), a button held through reset cannot start a press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
      r_warm  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_btn_s <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
      if (r_warm[1] && !r_btn_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_btn_s && r_armed) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!r_btn_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_DONE) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!r_btn_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (r_btn_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_DONE) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Strobe is registered on the PRESS_WAIT -> PRESSED transition only, so holding gives one pulse.
  always_comb begin
    w_pulse_nxt = (r_state == PRESS_WAIT) && r_btn_s && (r_cnt == CNT_DONE);
  end

  assign o_btn_pulse = r_pulse;

endmodule

// File: rtl/exec_button_ctrl.sv
// rtl/exec_button_ctrl.sv - run-control stage: debounced start button, halt, minimum exec high time
// Purpose: drives exec high on an accepted press and low on halt, never shorter than MIN_HIGH cycles.
// Ports: clock, reset (async active-high), bus (exec_button_ctrl_if.slave:
//        btn_raw/halt in, exec/btn_pulse/running out).
// Build option: EXEC_TOGGLE_EN - when defined, a press while running also stops exec.
module exec_button_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int MIN_HIGH        = 8
) (
  input logic               clock,
  input logic               reset,
  exec_button_ctrl_if.slave bus
);

  if (!min_high_ok(MIN_HIGH) || ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES))) begin : g_bad_params
    $error("exec_button_ctrl: MIN_HIGH must be 5..16 and 2**CNT_W > DEBOUNCE_CYCLES");
  end

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HIGH - 1);

  logic              w_btn_pulse;
  logic              w_stop_req;
  logic              r_exec;
  logic              r_stop_pend;
  logic [HOLD_W-1:0] r_hold;

  btn_sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_btn_raw   (bus.btn_raw),
    .o_btn_pulse (w_btn_pulse)
  );

`ifdef EXEC_TOGGLE_EN
  assign w_stop_req = bus.halt | w_btn_pulse;
`else
  assign w_stop_req = bus.halt;
`endif

  // While r_hold is nonzero, stop requests are only remembered; the stop lands on the first
  // edge that sees r_hold == 0, which gives exactly MIN_HIGH high cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_exec      <= 1'b0;
      r_hold      <= '0;
      r_stop_pend <= 1'b0;
    end else if (!r_exec) begin
      if (w_btn_pulse && !bus.halt) begin
        r_exec      <= 1'b1;
        r_hold      <= HOLD_INIT;
        r_stop_pend <= 1'b0;
      end
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HOLD_W'(1);
      if (w_stop_req) begin
        r_stop_pend <= 1'b1;
      end
    end else if (r_stop_pend || w_stop_req) begin
      r_exec      <= 1'b0;
      r_stop_pend <= 1'b0;
    end
  end

  assign bus.exec      = r_exec;
  assign bus.running   = r_exec;
  assign bus.btn_pulse = w_btn_pulse;

endmodule

// File: tb/tb_exec_button_ctrl.sv
// tb/tb_exec_button_ctrl.sv - scoreboard bench for exec_button_ctrl (DEBOUNCE_CYCLES=4, MIN_HIGH=8)
// Expected pulse edges and exec transitions are queued as stimulus is driven and popped by a monitor.
// Build option: EXEC_TOGGLE_EN selects the toggle expectations in test_toggle.
module tb_exec_button_ctrl;

  logic clock;
  logic reset;
  int   edge_n;
  int   n_checks;
  int   n_pass;
  int   pulse_q[$];
  int   exec_cyc_q[$];
  bit   exec_val_q[$];
  logic prev_exec;

  exec_button_ctrl_if ifc();

  exec_button_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20),
    .MIN_HIGH        (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  always @(negedge clock) begin
    if (reset) begin
      prev_exec = 1'b0;
    end else begin
      n_checks++;
      if (ifc.running !== ifc.exec) $display("FAIL running_tracks edge %0d: running=%b exec=%b", edge_n, ifc.running, ifc.exec);
      else n_pass++;
      if (ifc.btn_pulse === 1'b1) begin
        n_checks++;
        if (pulse_q.size() == 0) $display("FAIL pulse_unexpected: pulse at edge %0d, none expected", edge_n);
        else begin
          int e;
          e = pulse_q.pop_front();
          if (edge_n !== e) $display("FAIL pulse_edge: got edge %0d, expected edge %0d", edge_n, e);
          else n_pass++;
        end
      end
      if (ifc.exec !== prev_exec) begin
        n_checks++;
        if (exec_cyc_q.size() == 0) $display("FAIL exec_unexpected: exec=%b at edge %0d, no change expected", ifc.exec, edge_n);
        else begin
          int e;
          bit v;
          e = exec_cyc_q.pop_front();
          v = exec_val_q.pop_front();
          if (edge_n !== e || ifc.exec !== v) $display("FAIL exec_change: exec=%b at edge %0d, expected %b at edge %0d", ifc.exec, edge_n, v, e);
          else n_pass++;
        end
        prev_exec = ifc.exec;
      end
    end
  end

  task automatic press(input bit expect_rise, output int n);
    @(negedge clock);
    ifc.btn_raw = 1'b1;
    n = edge_n;
    pulse_q.push_back(n + 7);
    if (expect_rise) begin
      exec_cyc_q.push_back(n + 8);
      exec_val_q.push_back(1'b1);
    end
  endtask

  task automatic release_idle(input bit do_halt);
    @(negedge clock);
    ifc.btn_raw = 1'b0;
    if (do_halt) begin
      ifc.halt = 1'b1;
      exec_cyc_q.push_back(edge_n + 1);
      exec_val_q.push_back(1'b0);
      @(negedge clock);
      ifc.halt = 1'b0;
    end
    repeat (12) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.btn_raw = 1'b0;
    ifc.halt = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (ifc.exec !== 1'b0) $display("FAIL reset_exec: got %b, expected 0", ifc.exec); else n_pass++;
    n_checks++; if (ifc.btn_pulse !== 1'b0) $display("FAIL reset_pulse: got %b, expected 0", ifc.btn_pulse); else n_pass++;
    n_checks++; if (ifc.running !== 1'b0) $display("FAIL reset_running: got %b, expected 0", ifc.running); else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_clean_press();
    int n;
    press(1'b1, n);
    repeat (20) @(negedge clock);
    n_checks++; if (ifc.exec !== 1'b1) $display("FAIL clean_exec_high: got %b, expected 1", ifc.exec); else n_pass++;
    release_idle(1'b1);
    n_checks++; if (pulse_q.size() != 0 || exec_cyc_q.size() != 0) $display("FAIL clean_drain: %0d pulses/%0d exec events outstanding, expected 0", pulse_q.size(), exec_cyc_q.size()); else n_pass++;
  endtask

  task automatic test_bounce();
    int n;
    @(negedge clock); ifc.btn_raw = 1'b1; n = edge_n;
    @(negedge clock); ifc.btn_raw = 1'b0;
    @(negedge clock); ifc.btn_raw = 1'b1;
    @(negedge clock); ifc.btn_raw = 1'b0;
    @(negedge clock); ifc.btn_raw = 1'b1;
    pulse_q.push_back(n + 11);
    exec_cyc_q.push_back(n + 12);
    exec_val_q.push_back(1'b1);
    repeat (16) @(negedge clock);
    release_idle(1'b1);
    n_checks++; if (pulse_q.size() != 0 || exec_cyc_q.size() != 0) $display("FAIL bounce_drain: %0d pulses/%0d exec events outstanding, expected 0", pulse_q.size(), exec_cyc_q.size()); else n_pass++;
  endtask

  task automatic test_min_high();
    int n;
    press(1'b1, n);
    repeat (10) @(negedge clock);
    ifc.halt = 1'b1;
    exec_cyc_q.push_back(n + 16);
    exec_val_q.push_back(1'b0);
    @(negedge clock);
    ifc.halt = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (ifc.exec !== 1'b1 || ifc.running !== 1'b1) $display("FAIL min_high_hold: exec=%b running=%b, expected 1/1", ifc.exec, ifc.running); else n_pass++;
    repeat (5) @(negedge clock);
    n_checks++; if (ifc.exec !== 1'b0 || ifc.running !== 1'b0) $display("FAIL min_high_stop: exec=%b running=%b, expected 0/0", ifc.exec, ifc.running); else n_pass++;
    release_idle(1'b0);
    n_checks++; if (pulse_q.size() != 0 || exec_cyc_q.size() != 0) $display("FAIL min_high_drain: %0d pulses/%0d exec events outstanding, expected 0", pulse_q.size(), exec_cyc_q.size()); else n_pass++;
  endtask

  task automatic test_toggle();
    int n;
    int p;
    press(1'b1, n);
    repeat (10) @(negedge clock);
    ifc.btn_raw = 1'b0;
    repeat (10) @(negedge clock);
    press(1'b0, p);
`ifdef EXEC_TOGGLE_EN
    exec_cyc_q.push_back(p + 8);
    exec_val_q.push_back(1'b0);
    repeat (10) @(negedge clock);
    n_checks++; if (ifc.exec !== 1'b0) $display("FAIL toggle_second_press: exec=%b, expected 0", ifc.exec); else n_pass++;
    release_idle(1'b0);
`else
    repeat (10) @(negedge clock);
    n_checks++; if (ifc.exec !== 1'b1) $display("FAIL toggle_second_press: exec=%b, expected 1", ifc.exec); else n_pass++;
    release_idle(1'b1);
`endif
    n_checks++; if (pulse_q.size() != 0 || exec_cyc_q.size() != 0) $display("FAIL toggle_drain: %0d pulses/%0d exec events outstanding, expected 0", pulse_q.size(), exec_cyc_q.size()); else n_pass++;
  endtask

  task automatic test_halt_at_start();
    int n;
    press(1'b0, n);
    repeat (6) @(negedge clock);
    ifc.halt = 1'b1;
    repeat (3) @(negedge clock);
    ifc.halt = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (ifc.exec !== 1'b0) $display("FAIL halt_wins: exec=%b, expected 0", ifc.exec); else n_pass++;
    release_idle(1'b0);
    n_checks++; if (pulse_q.size() != 0 || exec_cyc_q.size() != 0) $display("FAIL halt_wins_drain: %0d pulses/%0d exec events outstanding, expected 0", pulse_q.size(), exec_cyc_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_debounce();
    int n;
    press(1'b1, n);
    repeat (10) @(negedge clock);
    ifc.btn_raw = 1'b0;
    repeat (10) @(negedge clock);
    ifc.btn_raw = 1'b1;
    repeat (4) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    n_checks++; if (ifc.exec !== 1'b0 || ifc.running !== 1'b0 || ifc.btn_pulse !== 1'b0) $display("FAIL async_reset: exec=%b running=%b pulse=%b, expected 0/0/0", ifc.exec, ifc.running, ifc.btn_pulse); else n_pass++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    n_checks++; if (ifc.exec !== 1'b0) $display("FAIL held_after_reset: exec=%b, expected 0", ifc.exec); else n_pass++;
    ifc.btn_raw = 1'b0;
    repeat (6) @(negedge clock);
    press(1'b1, n);
    repeat (20) @(negedge clock);
    release_idle(1'b1);
    n_checks++; if (pulse_q.size() != 0 || exec_cyc_q.size() != 0) $display("FAIL reset_drain: %0d pulses/%0d exec events outstanding, expected 0", pulse_q.size(), exec_cyc_q.size()); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    prev_exec = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_min_high();
    test_toggle();
    test_halt_at_start();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
